// File: rtl/cipher_stream_packer_if.sv
// rtl/cipher_stream_packer_if.sv - AXI-Stream word bus between the packer and the DMA sink
interface cipher_stream_packer_if;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

// File: rtl/cipher_stream_packer.sv
// rtl/cipher_stream_packer.sv - packs encrypted bytes into 32-bit stream words through a FWFT FIFO
module cipher_stream_packer #(
  parameter int FRAME_BYTES = 786432,
  parameter int DEPTH       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               byte_in,
  input  logic                     byte_valid,
  cipher_stream_packer_if.master   m_axis,
  output logic                     overflow,
  output logic [15:0]              frame_count,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(FRAME_BYTES + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_BYTES - 1);
  localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);

  typedef struct packed {
    logic        last;
    logic [3:0]  keep;
    logic [31:0] data;
  } word_t;

  logic [1:0]    lane_q, lane_d;
  logic [CW-1:0] bcnt_q, bcnt_d;
  logic [23:0]   part_q, part_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   level_q, level_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   fcnt_q, fcnt_d;

  word_t mem [DEPTH];
  word_t word_in, head;
  logic  valid, frame_end, push, pop, full, push_ok;

  // part_q only ever holds lanes below lane_q; higher lanes stay zero
  always_comb begin
    valid     = (level_q != '0);
    pop       = valid && m_axis.tready;
    full      = (level_q == FULL_LVL);
    frame_end = byte_valid && (bcnt_q == LAST_IDX);
    push      = byte_valid && ((lane_q == 2'd3) || frame_end);
    push_ok   = push && (!full || pop);

    word_in.last = frame_end;
    word_in.keep = 4'h1;
    word_in.data = {24'h0, byte_in};
    case (lane_q)
      2'd1: begin
        word_in.keep = 4'h3;
        word_in.data = {16'h0, byte_in, part_q[7:0]};
      end
      2'd2: begin
        word_in.keep = 4'h7;
        word_in.data = {8'h0, byte_in, part_q[15:0]};
      end
      2'd3: begin
        word_in.keep = 4'hF;
        word_in.data = {byte_in, part_q};
      end
      default: ;
    endcase

    lane_d  = lane_q;
    bcnt_d  = bcnt_q;
    part_d  = part_q;
    fcnt_d  = fcnt_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    ovf_d   = ovf_q;

    if (byte_valid) begin
      if (push) begin
        lane_d = 2'd0;
        part_d = '0;
      end else begin
        lane_d = lane_q + 2'd1;
        case (lane_q)
          2'd0:    part_d[7:0]   = byte_in;
          2'd1:    part_d[15:8]  = byte_in;
          default: part_d[23:16] = byte_in;
        endcase
      end
      if (frame_end) begin
        bcnt_d = '0;
        fcnt_d = fcnt_q + 16'd1;
      end else begin
        bcnt_d = bcnt_q + CW'(1);
      end
    end

    if (push && !push_ok) ovf_d = 1'b1;
    if (push_ok) wptr_d = wptr_q + AW'(1);
    if (pop)     rptr_d = rptr_q + AW'(1);
    case ({push_ok, pop})
      2'b10:   level_d = level_q + (AW + 1)'(1);
      2'b01:   level_d = level_q - (AW + 1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q  <= '0;
      bcnt_q  <= '0;
      part_q  <= '0;
      fcnt_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      lane_q  <= lane_d;
      bcnt_q  <= bcnt_d;
      part_q  <= part_d;
      fcnt_q  <= fcnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr_q] <= word_in;
  end

  assign head          = mem[rptr_q];
  assign m_axis.tvalid = valid;
  assign m_axis.tdata  = valid ? head.data : 32'h0;
  assign m_axis.tkeep  = valid ? head.keep : 4'h0;
  assign m_axis.tlast  = valid ? head.last : 1'b0;
  assign overflow      = ovf_q;
  assign frame_count   = fcnt_q;
  assign level         = level_q;
endmodule

// File: tb/tb_cipher_stream_packer.sv
// tb/tb_cipher_stream_packer.sv - randomized self-checking bench for cipher_stream_packer
module tb_cipher_stream_packer;
  localparam int DEPTH = 16;
  localparam int FB_A  = 6;
  localparam int FB_B  = 786432;
  localparam int MQ    = 512;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] byte_in;
  logic byte_valid;
  logic ovf_a, ovf_b;
  logic [15:0] fc_a, fc_b;
  logic [4:0] lvl_a, lvl_b;

  int n_vec = 0;
  int n_err = 0;
  int pops_b;

  cipher_stream_packer_if ax_a ();
  cipher_stream_packer_if ax_b ();

  cipher_stream_packer #(.FRAME_BYTES(FB_A), .DEPTH(DEPTH)) dut_a (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
    .m_axis(ax_a), .overflow(ovf_a), .frame_count(fc_a), .level(lvl_a));

  cipher_stream_packer #(.FRAME_BYTES(FB_B), .DEPTH(DEPTH)) dut_b (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
    .m_axis(ax_b), .overflow(ovf_b), .frame_count(fc_b), .level(lvl_b));

  always #5 clk = ~clk;

  // Reference: per instance a queue of expected words {last, keep, data} and a byte accumulator
  logic [36:0] mq [2][MQ];
  int          hd[2], tl[2], nb[2], fbc[2];
  logic [31:0] acc[2];
  logic        ovf_m[2];
  logic [15:0] fc_m[2];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_upd(input int k, input logic r, input logic bv, input logic [7:0] b, input logic rd);
    int sz;
    int fb;
    logic pop, full, last;
    logic [3:0] keep;
    fb = (k == 0) ? FB_A : FB_B;
    if (r) begin
      hd[k] = tl[k]; nb[k] = 0; acc[k] = '0; fbc[k] = 0; ovf_m[k] = 1'b0; fc_m[k] = '0;
    end else begin
      sz   = tl[k] - hd[k];
      pop  = (sz > 0) && rd;
      full = (sz == DEPTH);
      if (bv) begin
        acc[k] = acc[k] | (32'(b) << (8 * nb[k]));
        nb[k]++;
        fbc[k]++;
        last = (fbc[k] == fb);
        if (nb[k] == 4 || last) begin
          keep = 4'((1 << nb[k]) - 1);
          if (!full || pop) begin
            mq[k][tl[k] % MQ] = {last, keep, acc[k]};
            tl[k]++;
          end else begin
            ovf_m[k] = 1'b1;
          end
          if (last) begin
            fc_m[k] = fc_m[k] + 16'd1;
            fbc[k]  = 0;
          end
          nb[k]  = 0;
          acc[k] = '0;
        end
      end
      if (pop) hd[k]++;
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      int sz;
      logic [36:0] e;
      string nm;
      sz = tl[k] - hd[k];
      e  = (sz > 0) ? mq[k][hd[k] % MQ] : 37'h0;
      nm = (k == 0) ? "a" : "b";
      check_eq({nm, ".tvalid"}, (k == 0) ? ax_a.tvalid : ax_b.tvalid, 64'(sz != 0));
      check_eq({nm, ".level"},  (k == 0) ? lvl_a : lvl_b, 64'(sz));
      check_eq({nm, ".tdata"},  (k == 0) ? ax_a.tdata : ax_b.tdata, 64'(e[31:0]));
      check_eq({nm, ".tkeep"},  (k == 0) ? ax_a.tkeep : ax_b.tkeep, 64'(e[35:32]));
      check_eq({nm, ".tlast"},  (k == 0) ? ax_a.tlast : ax_b.tlast, 64'(e[36]));
      check_eq({nm, ".overflow"}, (k == 0) ? ovf_a : ovf_b, 64'(ovf_m[k]));
      check_eq({nm, ".frame_count"}, (k == 0) ? fc_a : fc_b, 64'(fc_m[k]));
    end
  endtask

  task automatic step(input logic r, input logic bv, input logic [7:0] b, input logic rd);
    check_outputs();
    if (ax_b.tvalid && rd && !r) pops_b++;
    rst = r; byte_valid = bv; byte_in = b;
    ax_a.tready = rd; ax_b.tready = rd;
    model_upd(0, r, bv, b, rd);
    model_upd(1, r, bv, b, rd);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic rd);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, rd);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      hd[k] = 0; tl[k] = 0; nb[k] = 0; fbc[k] = 0; acc[k] = '0; ovf_m[k] = 1'b0; fc_m[k] = '0;
    end

    // Reset held two cycles with random activity on the inputs
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      byte_valid = 1'($urandom); byte_in = 8'($urandom);
      ax_a.tready = 1'($urandom); ax_b.tready = ax_a.tready;
      @(posedge clk);
    end
    @(negedge clk);
    check_eq("rst.tvalid", ax_b.tvalid, 0);
    check_eq("rst.tdata",  ax_b.tdata, 0);
    check_eq("rst.tkeep",  ax_b.tkeep, 0);
    check_eq("rst.tlast",  ax_b.tlast, 0);
    check_eq("rst.overflow", ovf_b, 0);
    check_eq("rst.frame_count", fc_b, 0);
    check_eq("rst.level", lvl_b, 0);
    check_eq("rst.a.tvalid", ax_a.tvalid, 0);
    idle(3, 1'b1);

    // Basic packing
    step(1'b1, 1'b0, 8'h00, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b1, 8'(i), 1'b1);
      if (i == 4) begin
        check_eq("lat.tvalid", ax_b.tvalid, 1);
        check_eq("lat.tdata", ax_b.tdata, 64'h04030201);
      end
    end
    idle(3, 1'b1);

    // Frame residue on the 6-byte-frame instance, sink stalled so words queue up
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'hA0 + 8'(i), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'hB0 + 8'(i), 1'b0);
    check_eq("res.frame_count", fc_a, 1);
    check_eq("res.level", lvl_a, 3);
    idle(6, 1'b1);

    // Overflow: 17 full words into a stalled sink, then drain
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 68; i++) step(1'b0, 1'b1, 8'($urandom), 1'b0);
    check_eq("ovf.level", lvl_b, 16);
    check_eq("ovf.flag", ovf_b, 1);
    idle(20, 1'b1);
    check_eq("ovf.sticky", ovf_b, 1);

    // Backpressure: 64 bytes with gaps, random tready
    step(1'b1, 1'b0, 8'h00, 1'b0);
    pops_b = 0;
    begin
      int sent;
      sent = 0;
      for (int c = 0; c < 1000 && sent < 64; c++) begin
        if ($urandom_range(0, 9) < 7) begin
          step(1'b0, 1'b1, 8'($urandom), 1'($urandom));
          sent++;
        end else begin
          step(1'b0, 1'b0, 8'($urandom), 1'($urandom));
        end
      end
      check_eq("bp.sent", sent, 64);
    end
    idle(24, 1'b1);
    check_eq("bp.words", pops_b, 16);

    // Reset in the middle of a word
    step(1'b1, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b1, 8'h11, 1'b1);
    step(1'b0, 1'b1, 8'h22, 1'b1);
    step(1'b0, 1'b1, 8'h33, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    pops_b = 0;
    step(1'b0, 1'b1, 8'h44, 1'b1);
    step(1'b0, 1'b1, 8'h55, 1'b1);
    step(1'b0, 1'b1, 8'h66, 1'b1);
    step(1'b0, 1'b1, 8'h77, 1'b1);
    check_eq("mrst.tdata", ax_b.tdata, 64'h77665544);
    idle(4, 1'b1);
    check_eq("mrst.words", pops_b, 1);

    // Random soak across many 6-byte frames
    for (int i = 0; i < 300; i++) step(1'b0, 1'($urandom), 8'($urandom), 1'($urandom));
    idle(24, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cipher_stream_packer.md
Name: cipher_stream_packer

Overview:
- Downstream of the XOR encryptor stage: collects encrypted pixel bytes (one per valid cycle, no backpressure upstream) into 32-bit AXI-Stream words for DMA to PS memory.
- Buffers words in a small FIFO to absorb sink stalls.
- Marks frame end with tlast after FRAME_BYTES bytes.
- Reports overflow and completed-frame count.

Parameters:
- FRAME_BYTES, 786432, bytes per frame (512*512*3); any value >= 1, not required to be a multiple of 4.
- DEPTH, 16, FIFO depth in 32-bit words; power of 2, >= 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- byte_in  in  8  encrypted byte from the encryptor stage.
- byte_valid  in  1  byte_in valid this cycle; no ready is returned.
- m_axis_tdata  out  32  packed word; first byte of the word in [7:0].
- m_axis_tkeep  out  4  valid byte lanes, LSB-contiguous.
- m_axis_tlast  out  1  last word of frame.
- m_axis_tvalid  out  1  word available.
- m_axis_tready  in  1  sink accepts word.
- overflow  out  1  sticky: a word was dropped because the FIFO was full.
- frame_count  out  16  completed frames pushed to FIFO; wraps 0xFFFF->0.
- level  out  clog2(DEPTH)+1  FIFO occupancy in words.

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high; rst is sampled on the rising edge of clk.
- Reset values:
  - tdata=0, tkeep=0, tlast=0, tvalid=0, overflow=0, frame_count=0, level=0.
  - Lane index = 0, byte counter = 0, partial word cleared.
- Reset mid-operation discards the partial word, all FIFO contents and all counters. The next byte starts lane 0 of a new frame.
- Packing:
  - The lane index (0..3) selects the byte position for each accepted byte.
  - On each byte_valid, byte_in is stored in lane[idx] and the frame byte counter increments.
- Push condition: the byte fills lane 3, or it is byte number FRAME_BYTES of the frame.
  - The full word (stored lanes plus the current byte) is written to the FIFO on that same edge.
  - Latency: m_axis_tvalid is high in the cycle after the completing byte_valid cycle, if the FIFO was empty.
- Pushed word contents:
  - tkeep = lanes filled (4'hF full; residue r gives 4'b0001/0011/0111).
  - Unused lanes are 0.
  - tlast = 1 only on the frame-final word.
- At frame end:
  - Byte counter and lane index return to 0.
  - frame_count increments, even if the final word is dropped.
  - The next byte starts a new word and a new frame.
- FIFO is first-word-fall-through:
  - m_axis_tvalid = (level != 0); outputs present the head entry.
  - Pop occurs on tvalid && tready.
- AXI rule: while tvalid && !tready, tdata/tkeep/tlast are held stable. tvalid never drops without a handshake (except on rst).
- Push + pop in the same cycle:
  - Both take effect and level is unchanged.
  - This holds when full: the push is accepted because a slot frees that cycle.
  - This holds when empty: the word becomes head next cycle; no bypass.
- Overflow:
  - A push when level == DEPTH with no pop drops the new word.
  - overflow is set and stays 1 until rst.
  - Packing and counting continue normally.
- Pointers wrap modulo DEPTH. level ranges 0..DEPTH.

Test Plan:
- Reset: hold rst 2 cycles with random byte_valid and tready -> all outputs 0; after release with no input, tvalid stays 0.
- Basic packing, tready=1, bytes 01..08 on consecutive cycles:
  - Words 0x04030201 then 0x08070605, tkeep=F, tlast=0.
  - Each word's tvalid rises the cycle after its 4th byte.
- Frame residue, FRAME_BYTES=6, bytes A0..A5 then B0..B3:
  - 0xA3A2A1A0 keep F last 0.
  - 0x0000A5A4 keep 3 last 1; frame_count=1.
  - 0xB3B2B1B0 keep F last 0.
- Overflow, DEPTH=16, tready=0, push 17 full words:
  - level=16, overflow=1.
  - Then tready=1 drains exactly words 1..16 in order; word 17 is absent; overflow stays 1.
- Backpressure: toggle tready pseudo-randomly while streaming 64 bytes with gaps:
  - tdata/tkeep/tlast constant across every stalled cycle.
  - All 16 words are received in order with no duplicates.
  - level matches the scoreboard every cycle.
- Mid-word reset: bytes 11,22,33, rst 1 cycle, then 44,55,66,77 -> exactly one word, 0x77665544; no word containing 11/22/33.
